// File: rtl/fuzz_resp_misr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fuzz_resp_misr : folds fuzz response vectors into a 32-bit MISR and checks
// signature/count against golden values.                         Rev 1.0
// ---------------------------------------------------------------------------
module fuzz_resp_misr #(
    parameter int          DATA_W = 330,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] SEED   = 32'hFFFFFFFF,
    parameter int          CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              finish,
    input  logic [31:0]       exp_sig,
    input  logic [CNT_W-1:0]  exp_count,
    output logic [31:0]       sig,
    output logic [CNT_W-1:0]  sample_count,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail
);

    localparam int NUM_LANES = (DATA_W + 31) / 32;
    localparam int SH_W      = NUM_LANES * 32;
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_SHIFT = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [SH_W-1:0]    shreg_q, shreg_d;
    logic               fpend_q, fpend_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic [31:0]        fold_w;
    logic               match_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            lane_q  <= '0;
            shreg_q <= '0;
            fpend_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
            fpend_q <= fpend_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    // The low lane of the shift register is always the next lane to fold.
    assign fold_w  = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ shreg_q[31:0];
    assign match_w = (sig_q == exp_sig) && (cnt_q == exp_count);

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        shreg_d = shreg_q;
        fpend_d = fpend_q;
        pass_d  = pass_q;
        fail_d  = fail_q;

        if (start) begin
            state_d = S_ACCUM;
            sig_d   = SEED;
            cnt_d   = '0;
            lane_d  = '0;
            fpend_d = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        shreg_d              = '0;
                        shreg_d[DATA_W-1:0]  = in_data;
                        lane_d               = '0;
                        state_d              = S_SHIFT;
                        if (finish) begin
                            fpend_d = 1'b1;
                        end
                    end else if (finish) begin
                        state_d = S_CMP;
                    end
                end
                S_SHIFT: begin
                    sig_d   = fold_w;
                    shreg_d = shreg_q >> 32;
                    if (lane_q == LAST_LANE) begin
                        lane_d  = '0;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                        state_d = (fpend_q || finish) ? S_CMP : S_ACCUM;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                        if (finish) begin
                            fpend_d = 1'b1;
                        end
                    end
                end
                S_CMP: begin
                    pass_d  = match_w;
                    fail_d  = !match_w;
                    fpend_d = 1'b0;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (state_q == S_ACCUM);
    assign busy         = (state_q == S_ACCUM) || (state_q == S_SHIFT) || (state_q == S_CMP);
    assign done         = (state_q == S_DONE);
    assign pass         = done && pass_q;
    assign fail         = done && fail_q;
    assign sig          = sig_q;
    assign sample_count = cnt_q;

endmodule

`default_nettype wire
